// File: rtl/pipe_column_gen_if.sv
// Scroll-step interface between the game controller and the pipe column generator.
// The master drives the scroll controls and random source; the slave returns the column and status.
interface pipe_column_gen_if #(
  parameter int ROWS   = 16,
  parameter int LFSR_W = 10,
  parameter int CNT_W  = 8
);
  logic                    enable;
  logic                    advance;
  logic [LFSR_W-1:0]       lfsr;
  logic [ROWS-1:0]         column;
  logic                    col_valid;
  logic [$clog2(ROWS)-1:0] gap_top;
  logic [$clog2(ROWS):0]   gap_h;
  logic [CNT_W-1:0]        pipe_count;

  modport master (
    output enable, advance, lfsr,
    input  column, col_valid, gap_top, gap_h, pipe_count
  );

  modport slave (
    input  enable, advance, lfsr,
    output column, col_valid, gap_top, gap_h, pipe_count
  );
endinterface

// File: rtl/pipe_column_gen.sv
// Emits one playfield column per scroll step: SPACING empty columns, then PIPE_W pipe columns
// whose gap is placed from the LFSR and shrinks with the number of completed pipes.
module pipe_column_gen #(
  parameter int ROWS       = 16,
  parameter int LFSR_W     = 10,
  parameter int PIPE_W     = 1,
  parameter int SPACING    = 3,
  parameter int GAP_H_MAX  = 6,
  parameter int GAP_H_MIN  = 3,
  parameter int LEVEL_STEP = 4,
  parameter int MARGIN     = 1,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  pipe_column_gen_if.slave  bus
);
  localparam int RW   = $clog2(ROWS);
  localparam int CMAX = (SPACING > PIPE_W) ? SPACING : PIPE_W;
  localparam int CW   = $clog2(CMAX + 1) + 1;

  localparam logic [RW:0]    RBASE    = (RW+1)'(ROWS - 2*MARGIN + 1);
  localparam logic [RW-1:0]  MARGIN_C = RW'(MARGIN);
  localparam logic [RW:0]    GH_MAX_C = (RW+1)'(GAP_H_MAX);
  localparam logic [RW:0]    GH_MIN_C = (RW+1)'(GAP_H_MIN);
  localparam logic [CW-1:0]  SP_C     = CW'(SPACING);
  localparam logic [CW-1:0]  PW_LAST  = CW'(PIPE_W - 1);

  typedef enum logic [1:0] {IDLE, SPACE, PIPE} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [ROWS-1:0]   column;
  logic              col_valid;
  logic [RW-1:0]     gap_top;
  logic [RW:0]       gap_h;
  logic [CNT_W-1:0]  pipe_count;

  logic [RW:0]       r_mod, rem, gap_end;
  logic [RW-1:0]     gap_top_nx;
  logic [ROWS-1:0]   pipe_col;
  logic [CNT_W-1:0]  pc_nx;
  logic [RW:0]       gh_nx;

  // r_mod is never zero because ROWS >= GAP_H_MAX + 2*MARGIN, so the gap stays clear of the margins.
  always_comb begin
    r_mod      = RBASE - gap_h;
    rem        = {1'b0, bus.lfsr[RW-1:0]} % r_mod;
    gap_top_nx = MARGIN_C + rem[RW-1:0];
    gap_end    = {1'b0, gap_top_nx} + gap_h;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    assign pipe_col[i] = !(((RW+1)'(i) >= {1'b0, gap_top_nx}) && ((RW+1)'(i) < gap_end));
  end

  always_comb begin
    int level;
    pc_nx = (pipe_count == '1) ? pipe_count : pipe_count + CNT_W'(1);
    level = int'(pc_nx) / LEVEL_STEP;
    gh_nx = (level >= GAP_H_MAX - GAP_H_MIN) ? GH_MIN_C : (RW+1)'(GAP_H_MAX - level);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      column     <= '0;
      col_valid  <= 1'b0;
      gap_top    <= MARGIN_C;
      gap_h      <= GH_MAX_C;
      pipe_count <= '0;
    end else if (!bus.enable) begin
      // pipe_count and gap_h survive a pause so difficulty carries over
      state     <= IDLE;
      cnt       <= '0;
      column    <= '0;
      col_valid <= 1'b0;
    end else begin
      col_valid <= bus.advance;
      if (bus.advance) begin
        case (state)
          IDLE: begin
            column <= '0;
            if (SPACING == 1) begin
              state <= PIPE;
              cnt   <= '0;
            end else begin
              state <= SPACE;
              cnt   <= CW'(1);
            end
          end
          SPACE: begin
            column <= '0;
            if (cnt + CW'(1) == SP_C) begin
              state <= PIPE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          PIPE: begin
            if (cnt == '0) begin
              gap_top <= gap_top_nx;
              column  <= pipe_col;
            end
            if (cnt == PW_LAST) begin
              pipe_count <= pc_nx;
              gap_h      <= gh_nx;
              state      <= SPACE;
              cnt        <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.column     = column;
  assign bus.col_valid  = col_valid;
  assign bus.gap_top    = gap_top;
  assign bus.gap_h      = gap_h;
  assign bus.pipe_count = pipe_count;

  if (LFSR_W > RW) begin : g_lfsr_hi
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^bus.lfsr[LFSR_W-1:RW];
  end
endmodule

// File: tb/tb_pipe_column_gen.sv
// Directed bench: PIPE_W=1 instance for pattern, difficulty, saturation and pause;
// PIPE_W=2 instance for reset in the middle of a pipe.
module tb_pipe_column_gen;
  logic clk = 1'b0;
  logic reset_a, reset_b;
  int   passes = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  pipe_column_gen_if #(.ROWS(16), .LFSR_W(10), .CNT_W(8)) bus_a ();
  pipe_column_gen_if #(.ROWS(16), .LFSR_W(10), .CNT_W(8)) bus_b ();

  pipe_column_gen #(.PIPE_W(1)) u_a (.clk(clk), .reset(reset_a), .bus(bus_a));
  pipe_column_gen #(.PIPE_W(2)) u_b (.clk(clk), .reset(reset_b), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // one advance pulse; outputs are observable on return
  task automatic step_a();
    @(negedge clk) bus_a.advance = 1'b1;
    @(negedge clk) bus_a.advance = 1'b0;
  endtask

  task automatic step_b();
    @(negedge clk) bus_b.advance = 1'b1;
    @(negedge clk) bus_b.advance = 1'b0;
  endtask

  task automatic pipe_a(input int n);
    for (int p = 0; p < n; p++)
      for (int s = 0; s < 4; s++) step_a();
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    bus_a.enable = 1'b0; bus_a.advance = 1'b0; bus_a.lfsr = '0;
    bus_b.enable = 1'b0; bus_b.advance = 1'b0; bus_b.lfsr = '0;
    repeat (2) @(negedge clk);
    reset_a = 1'b0;

    chk("rst_column",  bus_a.column,     32'h0);
    chk("rst_valid",   bus_a.col_valid,  32'h0);
    chk("rst_gap_top", bus_a.gap_top,    32'd1);
    chk("rst_gap_h",   bus_a.gap_h,      32'd6);
    chk("rst_count",   bus_a.pipe_count, 32'd0);

    // first pipe: lfsr=5, R=9 -> gap_top 6, rows 6..11 open
    bus_a.enable = 1'b1; bus_a.lfsr = 10'h005;
    for (int k = 0; k < 3; k++) begin
      step_a();
      chk("space_column", bus_a.column,    32'h0);
      chk("space_valid",  bus_a.col_valid, 32'h1);
    end
    step_a();
    chk("p1_column",  bus_a.column,     32'hF03F);
    chk("p1_valid",   bus_a.col_valid,  32'h1);
    chk("p1_gap_top", bus_a.gap_top,    32'd6);
    chk("p1_gap_h",   bus_a.gap_h,      32'd6);
    chk("p1_count",   bus_a.pipe_count, 32'd1);
    @(negedge clk);
    chk("valid_pulse", bus_a.col_valid, 32'h0);
    chk("column_hold", bus_a.column,    32'hF03F);

    // after 4 pipes gap shrinks to 5; lfsr low nibble F -> 15 % 10 = 5 -> gap_top 6
    pipe_a(3);
    chk("p4_count", bus_a.pipe_count, 32'd4);
    chk("p4_gap_h", bus_a.gap_h,      32'd5);
    bus_a.lfsr = 10'h3FF;
    pipe_a(1);
    chk("p5_column",  bus_a.column,  32'hF83F);
    chk("p5_gap_top", bus_a.gap_top, 32'd6);
    chk("p5_gap_h",   bus_a.gap_h,   32'd5);

    pipe_a(7);
    chk("p12_count", bus_a.pipe_count, 32'd12);
    chk("p12_gap_h", bus_a.gap_h,      32'd3);
    bus_a.lfsr = 10'h000;
    pipe_a(1);
    chk("p13_column",  bus_a.column,  32'hFFF1);
    chk("p13_gap_top", bus_a.gap_top, 32'd1);

    pipe_a(300);
    chk("sat_count", bus_a.pipe_count, 32'd255);
    chk("sat_gap_h", bus_a.gap_h,      32'd3);

    // pause mid-SPACE
    step_a();
    chk("pre_pause_column", bus_a.column, 32'h0);
    bus_a.enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step_a();
      chk("pause_valid",  bus_a.col_valid, 32'h0);
      chk("pause_column", bus_a.column,    32'h0);
    end
    chk("pause_count", bus_a.pipe_count, 32'd255);
    chk("pause_gap_h", bus_a.gap_h,      32'd3);
    bus_a.enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_a();
      chk("resume_space_column", bus_a.column,    32'h0);
      chk("resume_space_valid",  bus_a.col_valid, 32'h1);
    end
    step_a();
    chk("resume_pipe_column", bus_a.column, 32'hFFF1);

    // PIPE_W=2: reset after the first pipe column
    reset_b = 1'b0;
    bus_b.enable = 1'b1; bus_b.lfsr = 10'h005;
    for (int k = 0; k < 4; k++) step_b();
    chk("b_p1_column", bus_b.column,     32'hF03F);
    chk("b_p1_count",  bus_b.pipe_count, 32'd0);
    reset_b = 1'b1; bus_b.advance = 1'b1;
    @(negedge clk);
    reset_b = 1'b0; bus_b.advance = 1'b0;
    chk("b_rst_column", bus_b.column,     32'h0);
    chk("b_rst_valid",  bus_b.col_valid,  32'h0);
    chk("b_rst_count",  bus_b.pipe_count, 32'd0);
    chk("b_rst_gap_h",  bus_b.gap_h,      32'd6);
    @(negedge clk);
    chk("b_no_second_col", bus_b.column,    32'h0);
    chk("b_no_valid",      bus_b.col_valid, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/pipe_column_gen.md
Name: pipe_column_gen

Overview:
- Parametrised successor of the single-column pipe generator for the scrolling LED-matrix Flappy Bird playfield.
- On each scroll `advance` it emits one playfield column. The column stream is a repeating pattern of SPACING empty columns followed by PIPE_W identical pipe columns.
- The gap position is drawn from the LFSR. The gap height shrinks with score, which gives the difficulty ramp.
- Sits between the LFSR and the playfield shift register. `col_valid` tells the shifter to load `column` into the right-most position.

Parameters:
- ROWS, 16: column height (playfield rows).
- LFSR_W, 10: LFSR input width. Must be >= $clog2(ROWS).
- PIPE_W, 1: number of consecutive pipe columns per pipe.
- SPACING, 3: number of empty columns before each pipe.
- GAP_H_MAX, 6: starting gap height, in rows.
- GAP_H_MIN, 3: minimum gap height. Must be >= 1 and <= GAP_H_MAX.
- LEVEL_STEP, 4: number of completed pipes per 1-row gap shrink.
- MARGIN, 1: rows always solid at the top and at the bottom. Requires ROWS >= GAP_H_MAX + 2*MARGIN.
- CNT_W, 8: width of the pipe counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: game running.
- advance, input, 1: one-cycle scroll-step request.
- lfsr, input, LFSR_W: random source.
- column, output, ROWS: current column. Bit i = row i, row 0 = top; 1 = pipe, 0 = empty.
- col_valid, output, 1: one-cycle pulse when `column` has been updated.
- gap_top, output, $clog2(ROWS): first gap row of the current or last pipe.
- gap_h, output, $clog2(ROWS)+1: current gap height.
- pipe_count, output, CNT_W: number of completed pipes.

Behaviour:
- Reset (synchronous, active-high, clock clk), applied at any time including mid-pipe. Next edge gives:
  - state = IDLE, column = 0, col_valid = 0, gap_top = MARGIN, gap_h = GAP_H_MAX, pipe_count = 0.
  - Internal column counter = 0.
- States are IDLE, SPACE and PIPE. All transitions happen on a clk edge where `advance` = 1 and `enable` = 1. With `advance` = 0, state and outputs hold, and col_valid = 0.
- IDLE:
  - Output column = 0.
  - An edge with enable = 1 and advance = 1 acts as the first SPACE column: it emits 0 and sets cnt = 1. The next state is SPACE, or PIPE if SPACING = 1.
  - enable = 1 with advance = 0 stays in IDLE.
- SPACE:
  - Each advance emits column = 0 and increments cnt.
  - When SPACING columns have been emitted, go to PIPE with cnt = 0.
- PIPE, first column:
  - On the advance edge of the first pipe column, sample lfsr and latch gap_top = MARGIN + (lfsr[$clog2(ROWS)-1:0] % R), where R = ROWS - gap_h - 2*MARGIN + 1.
  - Emit column = all ones except rows gap_top .. gap_top+gap_h-1, which are 0. The column must reflect the newly latched gap_top in the same update.
- PIPE, remaining columns:
  - The remaining PIPE_W-1 columns repeat the same column; lfsr is ignored.
- Pipe completion, on the edge emitting the last pipe column:
  - pipe_count increments, saturating at 2^CNT_W - 1.
  - gap_h updates to max(GAP_H_MIN, GAP_H_MAX - new_pipe_count / LEVEL_STEP).
  - The next state is SPACE with cnt = 0.
  - The new gap_h applies from the next pipe onward.
- Latency: column and col_valid update on the edge that samples advance. col_valid is high for exactly that one following cycle. column holds until the next update.
- enable = 0 at any edge, regardless of advance:
  - Go to IDLE, column = 0, col_valid = 0.
  - pipe_count and gap_h are retained.
  - On re-enable the sequence restarts from SPACE with a fresh count.
- Modulo is over a $clog2(ROWS)-bit value; the result is always < R, so the gap never enters the margin rows.

Test Plan:
- Reset, then enable = 1 and lfsr = 10'h005 with 4 advance pulses. Required response:
  - Advances 1-3 each give column = 16'h0000 with a col_valid pulse.
  - Advance 4 gives column = 16'hF03F, gap_top = 6, gap_h = 6, pipe_count = 1.
- Drive 4 complete pipes. Then set lfsr[3:0] = 4'hF and drive the next pipe. Required response: gap_h = 5, R = 10, gap_top = 6, column = 16'hF83F.
- Drive 12 complete pipes, then lfsr = 0. Required response: gap_h = 3, gap_top = 1, column = 16'hFFF1.
- Drive 300 pipes with CNT_W = 8. Required response: pipe_count saturates at 255 and gap_h stays at 3.
- Drop enable mid-SPACE, then re-enable. Required response:
  - While enable = 0, advance pulses produce no col_valid and column = 0.
  - After re-enable, exactly 3 empty columns precede the next pipe.
- Assert reset mid-PIPE with PIPE_W = 2 after the first pipe column. Required response: next cycle column = 0, pipe_count = 0, gap_h = 6, and no second pipe column is emitted.
